// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
//   TNEW_W_DEF   : default Tnew width
//   NOP_INSTR    : instruction word carried by a bubble
//   REG_ZERO     : GRF write address carried by a bubble ($0, never forwarded)
//   tnew_sat_dec : max(t-1, 0) at the default Tnew width
package pipe_pkg;

  localparam int          TNEW_W_DEF = 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  function automatic logic [TNEW_W_DEF-1:0] tnew_sat_dec(input logic [TNEW_W_DEF-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W_DEF'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_tnew_dec.sv
// Saturating Tnew decrement: out = max(in-1, 0), unsigned, W bits.
//   in  : Tnew before the stage boundary
//   out : Tnew after the stage boundary (0 stays 0)
module tnew_dec #(
  parameter int W = 2
) (
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  assign out = (in == '0) ? '0 : in - W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register placed between two CPU stages.
// Carries valid/instr/PC/NCH data channels/GRF write address/Tnew, with
// stall hold, flush-to-bubble, optional Tnew countdown while held, and a
// saturating count of flushes since reset.
//   clk, reset (async, active low)
//   stall, flush           : control, flush wins when both are high
//   in_valid .. in_tnew    : upstream stage fields
//   out_valid .. out_tnew  : registered fields, seen by the hazard unit
//   flush_cnt              : saturating flush counter
module pipe_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int NCH           = 2,
  parameter int PC_W          = 32,
  parameter int TNEW_W        = pipe_pkg::TNEW_W_DEF,
  parameter bit DEC_ON_HOLD   = 1'b0,
  parameter bit FLUSH_KEEP_PC = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [4:0]            in_wa,
  input  logic [TNEW_W-1:0]     in_tnew,
  output logic                  out_valid,
  output logic [31:0]           out_instr,
  output logic [PC_W-1:0]       out_pc,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [4:0]            out_wa,
  output logic [TNEW_W-1:0]     out_tnew,
  output logic [CNT_W-1:0]      flush_cnt
);
  import pipe_pkg::*;

  logic [TNEW_W-1:0] tnew_load, tnew_hold;
  logic [NCH-1:0][DATA_W-1:0] in_ch, data_q;

  // Load path ages upstream Tnew by one stage; hold path ages the held value.
  tnew_dec #(.W(TNEW_W)) u_dec_load (.in(in_tnew),  .out(tnew_load));
  tnew_dec #(.W(TNEW_W)) u_dec_hold (.in(out_tnew), .out(tnew_hold));

  // Control fields. A bubble always carries wa=0/tnew=0 so the hazard unit
  // never matches on it; an invalid load is turned into the same shape.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= '0;
      out_wa    <= REG_ZERO;
      out_tnew  <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= FLUSH_KEEP_PC ? in_pc : '0;
      out_wa    <= REG_ZERO;
      out_tnew  <= '0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (stall) begin
      if (DEC_ON_HOLD) out_tnew <= tnew_hold;
    end else begin
      out_valid <= in_valid;
      out_instr <= in_valid ? in_instr  : NOP_INSTR;
      out_pc    <= in_pc;
      out_wa    <= in_valid ? in_wa     : REG_ZERO;
      out_tnew  <= in_valid ? tnew_load : '0;
    end
  end

  // Data channels share the control; channel k sits at [k*DATA_W +: DATA_W].
  assign in_ch    = in_data;
  assign out_data = data_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)      data_q[k] <= '0;
      else if (flush)  data_q[k] <= '0;
      else if (!stall) data_q[k] <= in_ch[k];
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_wa = '0;
  logic [1:0]  in_tnew = '0;

  logic        o0_valid, o1_valid;
  logic [31:0] o0_instr, o1_instr, o0_pc, o1_pc;
  logic [63:0] o0_data, o1_data;
  logic [4:0]  o0_wa, o1_wa;
  logic [1:0]  o0_tnew, o1_tnew;
  logic [15:0] o0_cnt;
  logic [3:0]  o1_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // u0: plain hold, bubble PC = 0, 16-bit counter
  pipe_stage_reg u0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_wa(in_wa), .in_tnew(in_tnew),
    .out_valid(o0_valid), .out_instr(o0_instr), .out_pc(o0_pc), .out_data(o0_data),
    .out_wa(o0_wa), .out_tnew(o0_tnew), .flush_cnt(o0_cnt));

  // u1: Tnew counts down while held, bubble keeps PC, 4-bit counter
  pipe_stage_reg #(.DEC_ON_HOLD(1'b1), .FLUSH_KEEP_PC(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
    .in_wa(in_wa), .in_tnew(in_tnew),
    .out_valid(o1_valid), .out_instr(o1_instr), .out_pc(o1_pc), .out_data(o1_data),
    .out_wa(o1_wa), .out_tnew(o1_tnew), .flush_cnt(o1_cnt));

  // Reference model: one record per DUT, updated from the operating rules.
  typedef struct {
    bit          valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] data;
    logic [4:0]  wa;
    int          tnew;
    int          cnt;
  } mdl_t;

  mdl_t m[2];
  bit   dec_hold[2] = '{1'b0, 1'b1};
  bit   keep_pc[2]  = '{1'b0, 1'b1};
  int   cnt_max[2]  = '{65535, 15};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].valid = 0; m[i].instr = 0; m[i].pc = 0; m[i].data = 0;
      m[i].wa = 0; m[i].tnew = 0; m[i].cnt = 0;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".d0.valid"}, 64'(o0_valid), 64'(m[0].valid));
    chk({tag, ".d0.instr"}, 64'(o0_instr), 64'(m[0].instr));
    chk({tag, ".d0.pc"},    64'(o0_pc),    64'(m[0].pc));
    chk({tag, ".d0.data"},  o0_data,       m[0].data);
    chk({tag, ".d0.wa"},    64'(o0_wa),    64'(m[0].wa));
    chk({tag, ".d0.tnew"},  64'(o0_tnew),  64'(m[0].tnew));
    chk({tag, ".d0.cnt"},   64'(o0_cnt),   64'(m[0].cnt));
    chk({tag, ".d1.valid"}, 64'(o1_valid), 64'(m[1].valid));
    chk({tag, ".d1.instr"}, 64'(o1_instr), 64'(m[1].instr));
    chk({tag, ".d1.pc"},    64'(o1_pc),    64'(m[1].pc));
    chk({tag, ".d1.data"},  o1_data,       m[1].data);
    chk({tag, ".d1.wa"},    64'(o1_wa),    64'(m[1].wa));
    chk({tag, ".d1.tnew"},  64'(o1_tnew),  64'(m[1].tnew));
    chk({tag, ".d1.cnt"},   64'(o1_cnt),   64'(m[1].cnt));
  endtask

  // One clock edge: drive inputs, advance the model, compare after the edge.
  task automatic step(string tag, bit st, bit fl, bit iv, logic [31:0] ins,
                      logic [31:0] pc, logic [63:0] dat, logic [4:0] wa, int tn);
    stall = st; flush = fl; in_valid = iv; in_instr = ins; in_pc = pc;
    in_data = dat; in_wa = wa; in_tnew = 2'(tn);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        m[i].valid = 0; m[i].instr = 0; m[i].data = 0; m[i].wa = 0; m[i].tnew = 0;
        m[i].pc = keep_pc[i] ? pc : 32'h0;
        if (m[i].cnt < cnt_max[i]) m[i].cnt++;
      end else if (st) begin
        if (dec_hold[i] && m[i].tnew > 0) m[i].tnew--;
      end else begin
        m[i].valid = iv;
        m[i].pc    = pc;
        m[i].data  = dat;
        m[i].instr = iv ? ins : 32'h0;
        m[i].wa    = iv ? wa : 5'd0;
        m[i].tnew  = (iv && tn > 0) ? tn - 1 : 0;
      end
    end
    check_all(tag);
  endtask

  initial begin
    int exp_hold1[3] = '{1, 0, 0};
    model_reset();

    // Reset state, then release away from the rising edge
    #12;
    check_all("reset");
    @(negedge clk) reset = 1'b1;

    // Basic load and Tnew aging
    step("load", 0, 0, 1, 32'h0123_4567, 32'h3000, 64'hdead_beef_cafe_f00d, 5'd8, 2);
    chk("load.tnew", 64'(o0_tnew), 64'd1);
    chk("load.wa",   64'(o0_wa),   64'd8);
    chk("load.pc",   64'(o0_pc),   64'h3000);
    step("tnew0", 0, 0, 1, 32'h1111_2222, 32'h3004, 64'h1, 5'd9, 0);
    chk("tnew0.tnew", 64'(o1_tnew), 64'd0);

    // Hold with out_tnew = 2
    step("pre_hold", 0, 0, 1, 32'hAAAA_5555, 32'h3008, 64'h2, 5'd10, 3);
    for (int k = 0; k < 3; k++) begin
      step("hold", 1, 0, 1, $urandom, $urandom, {$urandom, $urandom}, 5'd3, 3);
      chk("hold.d0.tnew", 64'(o0_tnew), 64'd2);
      chk("hold.d1.tnew", 64'(o1_tnew), 64'(exp_hold1[k]));
    end

    // Stall and flush together: flush wins
    step("stall_flush", 1, 1, 1, 32'hFFFF_0000, 32'h3010, 64'h5, 5'd7, 3);
    chk("sf.d0.pc",  64'(o0_pc),  64'h0);
    chk("sf.d1.pc",  64'(o1_pc),  64'h3010);
    chk("sf.d0.cnt", 64'(o0_cnt), 64'd1);

    // Invalid slot becomes a bubble shape
    step("invalid", 0, 0, 0, 32'h8765_4321, 32'h3014, 64'h77, 5'd31, 3);
    chk("inv.wa",   64'(o0_wa),   64'd0);
    chk("inv.tnew", 64'(o1_tnew), 64'd0);

    // Counter saturation on the 4-bit instance
    for (int k = 0; k < 20; k++)
      step("flushes", 0, 1, 1, $urandom, $urandom, {$urandom, $urandom}, 5'(k), 2);
    chk("sat.d1.cnt", 64'(o1_cnt), 64'd15);
    chk("sat.d0.cnt", 64'(o0_cnt), 64'd21);

    // Random traffic against the model
    for (int k = 0; k < 300; k++)
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom, {$urandom, $urandom},
           5'($urandom_range(0, 31)), $urandom_range(0, 3));

    // Fresh start, build flush_cnt=5 and out_tnew=2, then reset mid-cycle
    @(negedge clk) reset = 1'b0;
    model_reset();
    #1 check_all("rst_pulse");
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 5; k++)
      step("pre_rst_flush", 0, 1, 1, 32'h0, 32'h4000, 64'h0, 5'd1, 1);
    step("pre_rst_load", 0, 0, 1, 32'h1234_5678, 32'h4010, 64'h99, 5'd12, 3);
    chk("pre_rst.tnew", 64'(o0_tnew), 64'd2);
    chk("pre_rst.cnt",  64'(o0_cnt),  64'd5);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk) reset = 1'b1;
    step("post_rst", 0, 0, 1, 32'hCAFE_0001, 32'h5000, 64'h42, 5'd4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU, replacing the fixed per-stage registers (D→E, E→M, M→W) with one block instantiated once per boundary. It carries instruction, PC, N data channels, the GRF write address and the stage-relative Tnew hazard count. It adds a valid bit, stall hold, flush-to-bubble, an optional Tnew countdown while held, and a saturating flush counter. It sits between two stages and feeds the hazard unit with `out_tnew`/`out_wa`/`out_valid`.

## Interface
- `DATA_W`, 32, width of each data channel
- `NCH`, 2, number of data channels (e.g. ALU result, GRF RD2)
- `PC_W`, 32, PC width
- `TNEW_W`, 2, Tnew width
- `DEC_ON_HOLD`, 0, 1 = Tnew keeps decrementing while stalled
- `FLUSH_KEEP_PC`, 0, 1 = bubble inherits `in_pc` (EPC/delay-slot tracking), 0 = bubble PC is 0
- `CNT_W`, 16, flush counter width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold current contents
- `flush`  in  1  load a bubble
- `in_valid`  in  1  upstream slot holds a real instruction
- `in_instr`  in  32  instruction word
- `in_pc`  in  PC_W  instruction PC
- `in_data`  in  NCH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- `in_wa`  in  5  GRF write address
- `in_tnew`  in  TNEW_W  Tnew as seen in upstream stage
- `out_valid`, `out_instr`, `out_pc`, `out_data`, `out_wa`, `out_tnew`  out  same widths  registered copies
- `flush_cnt`  out  CNT_W  number of flushes since reset, saturating

## Operation
- Priority per edge: reset > flush > stall > load.
- Load (no stall, no flush): all outputs take inputs; `out_tnew` = `in_tnew` − 1, saturating at 0; if `in_valid`=0 then `out_wa`=0, `out_tnew`=0, `out_instr`=0.
- Stall (no flush): all fields hold; if `DEC_ON_HOLD`=1, `out_tnew` decrements saturating at 0; otherwise holds.
- Flush (with or without stall): `out_valid`=0, `out_instr`=0, `out_wa`=0, `out_tnew`=0, `out_data`=0; `out_pc` = `in_pc` if `FLUSH_KEEP_PC`=1 else 0; `flush_cnt` +1 unless at all-ones.
- Bubble invariant: whenever `out_valid`=0, `out_wa`=0 and `out_tnew`=0, so the hazard unit never forwards from or stalls on a bubble.
- No X handling: Tnew is always a defined number.

## Timing
- Latency 1 cycle input→output on load.
- Reset: asserting `reset` low clears every output and `flush_cnt` to 0 immediately, independent of `clk`; mid-stall or mid-flush state is discarded. First load occurs on the first rising edge after `reset` returns high.
- `stall` and `flush` sampled on the same edge as the data; both high → flush.
- Tnew arithmetic: unsigned, TNEW_W bits, max(in−1, 0); 0 stays 0.
- `flush_cnt` at 2^CNT_W−1 holds on further flushes.

## Structure
- Shared package `pipe_pkg`: `TNEW_W` default, `NOP_INSTR` (32'h0), `REG_ZERO` (5'd0), Tnew saturating-decrement function.
- One natural sub-module: `tnew_dec` (saturating decrement, TNEW_W-wide), used for both load and hold-decrement paths.
- Data channels generated with a per-channel loop; no per-channel control.

## Test plan
- Reset low mid-run with `out_tnew`=2, `flush_cnt`=5 → all outputs and `flush_cnt` 0 before next edge; stay 0 until `reset` high.
- Load `in_valid`=1, `in_tnew`=2, `in_wa`=8, `in_pc`=32'h3000 → next cycle `out_tnew`=1, `out_wa`=8, `out_pc`=32'h3000; `in_tnew`=0 → `out_tnew`=0.
- `stall`=1 for 3 cycles holding `out_tnew`=2: `DEC_ON_HOLD`=0 → stays 2; `DEC_ON_HOLD`=1 → 1, 0, 0.
- `stall`=1 and `flush`=1 with `in_pc`=32'h3010 → `out_valid`=0, `out_wa`=0, `out_tnew`=0, `out_pc`=32'h3010 (`FLUSH_KEEP_PC`=1) or 0 (`FLUSH_KEEP_PC`=0), `flush_cnt` +1.
- `in_valid`=0 with `in_wa`=31, `in_tnew`=3 → `out_wa`=0, `out_tnew`=0.
- `CNT_W`=4, 20 consecutive flushes → `flush_cnt` reaches 15 and holds.
